var_latency: RTL and testbench
==============================

# var_latency

Runtime-programmable delay line: each accepted sample (in_valid, in_data) reappears on out_valid/out_data exactly `len` enabled clock cycles later, with `len` reloadable at run time in 1..MAX_LENGTH. It is the parametrised successor of the fixed-length flip-flop delay chain. It adds per-sample valid tagging, a stall enable, an in-flight counter and a flush-on-reconfigure rule. It sits in datapaths where the delay depends on the mode, for example aligning side-band data with a variable-depth arithmetic pipeline.

## Interface
- MAX_LENGTH, 16, maximum latency in cycles; legal values ≥ 1, and the value need not be a power of two.
- WIDTH, 8, data width in bits.
- RESET_LENGTH, MAX_LENGTH, latency in effect after reset; legal range 1..MAX_LENGTH.
- LEN_W, derived localparam = clog2(MAX_LENGTH+1), width of length fields; not overridable.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  advance enable; when 0 the line is frozen.
- in_valid  in  1  sample present this cycle.
- in_data  in  WIDTH  sample payload.
- cfg_load  in  1  one-cycle strobe that loads cfg_len.
- cfg_len  in  LEN_W  requested latency.
- out_valid  out  1  delayed sample present.
- out_data  out  WIDTH  delayed payload; forced to 0 whenever out_valid=0.
- busy  out  1  at least one valid sample in flight (inflight != 0).
- inflight  out  LEN_W  count of valid samples held.
- cfg_err  out  1  one-cycle pulse: previous cfg_load had an out-of-range cfg_len.

## Operation
- Storage is a ring of MAX_LENGTH slots. Each slot holds WIDTH data bits plus one valid bit. Write pointer wr_ptr runs 0..MAX_LENGTH-1 and wraps explicitly (no power-of-two masking). Register len holds the current latency.
- Read slot = (wr_ptr − len) mod MAX_LENGTH, with wrap handled by conditional add of MAX_LENGTH. out_valid and out_data are combinational from the read slot.
- Enabled cycle (en=1, cfg_load=0):
  - slot[wr_ptr] ← {in_valid, in_data};
  - wr_ptr advances by one with wrap;
  - inflight ← inflight + in_valid − out_valid. A simultaneous +1/−1 nets to no change.
- Frozen cycle (en=0, cfg_load=0): no state change. Outputs hold their values and in_valid is ignored (the sample is dropped, with no error).
- cfg_load=1 takes priority and acts regardless of en:
  - len ← cfg_len if 1 ≤ cfg_len ≤ MAX_LENGTH. Otherwise len ← MAX_LENGTH for cfg_len > MAX_LENGTH, or len ← 1 for cfg_len = 0, and cfg_err pulses on the next cycle.
  - All valid bits and inflight clear.
  - wr_ptr is unchanged and the input sample that cycle is discarded.
  - out_valid is 0 from the cycle after the load until new samples arrive.
- cfg_load with cfg_len equal to the current len still flushes.
- Data bits are not reset; only valid bits, pointers, len, inflight and cfg_err are reset.
- inflight can never exceed len, because one slot is read per write.

## Timing
- Latency: a sample accepted on enabled edge k appears on out_valid with its data after exactly len enabled edges. Frozen cycles stretch the wall-clock delay one-for-one.
- Throughput: one sample per enabled cycle, with no bubbles.
- len = MAX_LENGTH: the read slot equals wr_ptr, so the output shows the slot about to be overwritten. This is legal: the read happens before the edge.
- Reset values (asserted asynchronously): out_valid=0, out_data=0, busy=0, inflight=0, cfg_err=0, wr_ptr=0, len=RESET_LENGTH, all valid bits 0.
- Reset mid-stream: all in-flight samples are lost and outputs go to reset values immediately, not waiting for an edge.
- Reset release: the first enabled edge after rst deasserts writes slot 0.

## Structure
- Package var_latency_pkg holds:
  - the clog2 function;
  - the localparam for LEN_W;
  - the wrap-subtract function used for the read index.
- Sub-module mod_counter (parameter MODULUS) provides wr_ptr: async reset, enable, wrap at MODULUS−1.
- Everything else (ring, valid vector, len register, inflight counter, cfg_err flop) lives in var_latency.

## Test plan
- Use MAX_LENGTH=5, WIDTH=8, RESET_LENGTH=5, en=1. Drive in_data 0x01..0x0A on consecutive cycles → out_data 0x01..0x0A appears cycles 5..14 and inflight saturates at 5.
- Apply a valid pulse 0xAB and hold en=0 for 3 cycles after edge 2 → 0xAB appears 5 enabled edges, or 8 clocks, after acceptance, and out_valid holds during the stall.
- Stream data, then cfg_load with cfg_len=2 → out_valid=0, inflight=0 on the next cycle. A new sample 0x33 exits 2 enabled edges after acceptance.
- Load cfg_len=7 (MAX_LENGTH=5) → cfg_err pulses once and the measured latency is 5. Load cfg_len=0 → cfg_err pulses and the measured latency is 1.
- Stream with gaps (valid pattern 1,0,1,1,0) across ≥ 3 pointer wraps with len=3 → the output valid pattern is identical shifted by 3, out_data=0 in the gaps, and inflight matches the count.
- Assert rst asynchronously mid-stream between edges → outputs go to reset values immediately. After release with len=RESET_LENGTH, the first sample has the correct latency and no stale data appears.

Source files
------------

// File: rtl/var_latency_pkg.sv
// Shared helpers for the programmable delay line: constant clog2, default widths
// and the modular subtract that turns the write pointer into the read pointer.
package var_latency_pkg;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

   localparam int unsigned MAX_LENGTH_DEF = 16;
   localparam int unsigned LEN_W_DEF      = clog2(MAX_LENGTH_DEF + 1);

   // ptr in 0..modulus-1, len in 1..modulus; wrap by conditional add, not masking
   function automatic int unsigned wrap_sub(input int unsigned ptr,
                                            input int unsigned len,
                                            input int unsigned modulus);
      return (ptr >= len) ? (ptr - len) : (ptr + modulus - len);
   endfunction

endpackage

// File: rtl/var_latency_mod_counter.sv
// Modulo-N up counter with enable and asynchronous active-high reset.
// Wraps explicitly at MODULUS-1, so N need not be a power of two.
module mod_counter
   import var_latency_pkg::*;
#(
   parameter int unsigned MODULUS = 16,
   parameter int unsigned W       = (MODULUS > 1) ? clog2(MODULUS) : 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = (cnt_q == W'(MODULUS - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/var_latency.sv
// Runtime-programmable delay line: ring of MAX_LENGTH valid-tagged slots, read
// len slots behind the write pointer, flushed on every configuration load.
module var_latency
   import var_latency_pkg::*;
#(
   parameter int unsigned MAX_LENGTH   = MAX_LENGTH_DEF,
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned RESET_LENGTH = MAX_LENGTH,
   localparam int unsigned LEN_W       = clog2(MAX_LENGTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             cfg_load_i,
   input  logic [LEN_W-1:0] cfg_len_i,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             busy_o,
   output logic [LEN_W-1:0] inflight_o,
   output logic             cfg_err_o
);

   localparam int unsigned PTR_W = (MAX_LENGTH > 1) ? clog2(MAX_LENGTH) : 1;

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  adv;
   logic [WIDTH-1:0]      data_q [MAX_LENGTH];
   logic [MAX_LENGTH-1:0] valid_q, valid_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [LEN_W-1:0]      inflight_q, inflight_d;
   logic                  cfg_err_q, cfg_err_d;

   // a load never advances the ring, whatever en_i says
   assign adv = en_i & ~cfg_load_i;

   mod_counter #(
      .MODULUS (MAX_LENGTH),
      .W       (PTR_W)
   ) u_wr_ptr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (adv),
      .cnt_o (wr_ptr)
   );

   assign rd_ptr = PTR_W'(wrap_sub(32'(wr_ptr), 32'(len_q), MAX_LENGTH));

   assign out_valid_o = valid_q[rd_ptr];
   assign out_data_o  = out_valid_o ? data_q[rd_ptr] : '0;
   assign inflight_o  = inflight_q;
   assign busy_o      = (inflight_q != '0);
   assign cfg_err_o   = cfg_err_q;

   always_comb begin
      len_d      = len_q;
      inflight_d = inflight_q;
      valid_d    = valid_q;
      cfg_err_d  = 1'b0;
      if (cfg_load_i) begin
         inflight_d = '0;
         valid_d    = '0;
         if (cfg_len_i == '0) begin
            len_d     = LEN_W'(1);
            cfg_err_d = 1'b1;
         end else if (cfg_len_i > LEN_W'(MAX_LENGTH)) begin
            len_d     = LEN_W'(MAX_LENGTH);
            cfg_err_d = 1'b1;
         end else begin
            len_d = cfg_len_i;
         end
      end else if (en_i) begin
         valid_d[wr_ptr] = in_valid_i;
         inflight_d      = inflight_q + LEN_W'(in_valid_i) - LEN_W'(out_valid_o);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q    <= '0;
         len_q      <= LEN_W'(RESET_LENGTH);
         inflight_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         len_q      <= len_d;
         inflight_q <= inflight_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   // payload storage carries no reset; the valid bits gate everything visible
   always_ff @(posedge clk_i) begin
      if (adv) begin
         data_q[wr_ptr] <= in_data_i;
      end
   end

endmodule

// File: tb/tb_var_latency.sv
// Directed bench for var_latency with MAX_LENGTH=5, WIDTH=8, RESET_LENGTH=5.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_var_latency;

   localparam int unsigned MAXL = 5;
   localparam int unsigned WD   = 8;
   localparam int unsigned LW   = 3;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          en_i;
   logic          in_valid_i;
   logic [WD-1:0] in_data_i;
   logic          cfg_load_i;
   logic [LW-1:0] cfg_len_i;
   logic          out_valid_o;
   logic [WD-1:0] out_data_o;
   logic          busy_o;
   logic [LW-1:0] inflight_o;
   logic          cfg_err_o;

   int total = 0;
   int bad   = 0;
   logic vin [0:22];

   var_latency #(
      .MAX_LENGTH   (MAXL),
      .WIDTH        (WD),
      .RESET_LENGTH (MAXL)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .cfg_load_i  (cfg_load_i),
      .cfg_len_i   (cfg_len_i),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .busy_o      (busy_o),
      .inflight_o  (inflight_o),
      .cfg_err_o   (cfg_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic drv(input logic v, input logic [WD-1:0] d);
      in_valid_i = v;
      in_data_i  = d;
   endtask

   task automatic load(input logic [LW-1:0] len);
      cfg_load_i = 1'b1;
      cfg_len_i  = len;
      tick();
      cfg_load_i = 1'b0;
      cfg_len_i  = '0;
   endtask

   // accept one sample, count enabled edges (acceptance edge included) until it shows
   task automatic measure(input logic [WD-1:0] d, input string tag, input int exp_lat);
      int n;
      drv(1'b1, d);
      tick();
      n = 1;
      while (!out_valid_o && n < 12) begin
         drv(1'b0, 8'h00);
         tick();
         n++;
      end
      drv(1'b0, 8'h00);
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_data"}, out_data_o, d);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int j, n, acc, ex, inf, ev, ed;
      rst_i = 1'b1; en_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0;
      cfg_load_i = 1'b0; cfg_len_i = '0;
      #2;
      chk("rst_valid", out_valid_o, 0);
      chk("rst_data", out_data_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_inflight", inflight_o, 0);
      chk("rst_cfg_err", cfg_err_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // full-length stream 0x01..0x0A
      for (int c = 0; c < 15; c++) begin
         drv(c < 10, 8'(c + 1));
         tick();
         n   = c + 1;
         j   = c - 4;
         ev  = (j >= 0 && j <= 9) ? 1 : 0;
         ed  = (ev != 0) ? j + 1 : 0;
         acc = (n < 10) ? n : 10;
         ex  = (n - 5 < 0) ? 0 : ((n - 5 > 10) ? 10 : n - 5);
         inf = acc - ex;
         chk($sformatf("s1_valid[%0d]", c), out_valid_o, ev);
         chk($sformatf("s1_data[%0d]", c), out_data_o, ed);
         chk($sformatf("s1_inflight[%0d]", c), inflight_o, inf);
         chk($sformatf("s1_busy[%0d]", c), busy_o, (inf != 0));
      end

      // stall stretches latency; dropped input while frozen
      drv(1'b1, 8'hAB); tick();
      drv(1'b0, 8'h00); tick();
      chk("stall_pre_valid", out_valid_o, 0);
      chk("stall_pre_inf", inflight_o, 1);
      en_i = 1'b0;
      drv(1'b1, 8'hEE);
      repeat (3) tick();
      chk("stall_inf", inflight_o, 1);
      chk("stall_valid", out_valid_o, 0);
      en_i = 1'b1;
      drv(1'b0, 8'h00);
      tick(); tick();
      chk("stall_edge4_valid", out_valid_o, 0);
      tick();
      chk("stall_edge5_valid", out_valid_o, 1);
      chk("stall_edge5_data", out_data_o, 8'hAB);
      en_i = 1'b0;
      repeat (2) tick();
      chk("stall_hold_valid", out_valid_o, 1);
      chk("stall_hold_data", out_data_o, 8'hAB);
      en_i = 1'b1;
      tick();
      chk("stall_exit_valid", out_valid_o, 0);
      chk("stall_exit_inf", inflight_o, 0);

      // reconfigure to 2 flushes in-flight samples
      for (int i = 0; i < 3; i++) begin
         drv(1'b1, 8'(8'h10 + i));
         tick();
      end
      chk("pre_flush_inf", inflight_o, 3);
      drv(1'b1, 8'h99);
      load(3'd2);
      drv(1'b0, 8'h00);
      chk("flush_valid", out_valid_o, 0);
      chk("flush_inf", inflight_o, 0);
      chk("flush_busy", busy_o, 0);
      chk("flush_err", cfg_err_o, 0);
      measure(8'h33, "len2", 2);
      tick();
      drv(1'b1, 8'h34); tick();
      drv(1'b0, 8'h00);
      chk("same_len_pre_inf", inflight_o, 1);
      load(3'd2);
      chk("same_len_inf", inflight_o, 0);
      tick();
      chk("same_len_valid", out_valid_o, 0);

      // out-of-range lengths clamp and pulse cfg_err once
      load(3'd7);
      chk("len7_err", cfg_err_o, 1);
      chk("len7_valid", out_valid_o, 0);
      tick();
      chk("len7_err_clear", cfg_err_o, 0);
      measure(8'h44, "len7", 5);
      tick();
      load(3'd0);
      chk("len0_err", cfg_err_o, 1);
      tick();
      chk("len0_err_clear", cfg_err_o, 0);
      measure(8'h55, "len0", 1);

      // gapped stream across several pointer wraps with len=3
      load(3'd3);
      chk("len3_err", cfg_err_o, 0);
      for (int c = 0; c < 23; c++) begin
         vin[c] = (c < 20) && ((c % 5 == 0) || (c % 5 == 2) || (c % 5 == 3));
         drv(vin[c], 8'(8'h60 + c));
         tick();
         ev  = (c >= 2) ? int'(vin[c-2]) : 0;
         ed  = (ev != 0) ? 8'h60 + c - 2 : 0;
         inf = 0;
         for (int k = c - 2; k <= c; k++) begin
            if (k >= 0 && vin[k]) inf++;
         end
         chk($sformatf("gap_valid[%0d]", c), out_valid_o, ev);
         chk($sformatf("gap_data[%0d]", c), out_data_o, ed);
         chk($sformatf("gap_inf[%0d]", c), inflight_o, inf);
      end

      // asynchronous reset between edges
      drv(1'b1, 8'h81); tick();
      drv(1'b1, 8'h82); tick();
      drv(1'b1, 8'h83); tick();
      chk("pre_rst_valid", out_valid_o, 1);
      chk("pre_rst_data", out_data_o, 8'h81);
      #2;
      rst_i = 1'b1;
      #1;
      chk("async_rst_valid", out_valid_o, 0);
      chk("async_rst_data", out_data_o, 0);
      chk("async_rst_busy", busy_o, 0);
      chk("async_rst_inf", inflight_o, 0);
      drv(1'b0, 8'h00);
      @(negedge clk_i);
      rst_i = 1'b0;
      measure(8'h77, "post_rst", 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
